// File: rtl/fir_pkg.sv
// Shared FIR datapath constants for the controller, sample buffer and MAC core.
package fir_pkg;

    localparam int unsigned INPUT_WIDTH  = 16;
    localparam int unsigned OUTPUT_WIDTH = 38;
    localparam int unsigned COEFF_COUNT  = 64;

endpackage

// File: rtl/fir_pipe_reg.sv
// Generic pipeline register: async active-high reset, sync clear, load enable.
module fir_pipe_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] q_q;

    // clr wins over en so a flush discards the inputs of that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fir_mac_core.sv
// FIR multiply-accumulate core: registered signed product feeding two interleaved
// partial sums (even/odd cycles) through a result/res_pipe feedback loop.
module fir_mac_core
    import fir_pkg::*;
#(
    parameter int unsigned InputWidth  = INPUT_WIDTH,
    parameter int unsigned OutputWidth = OUTPUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [InputWidth-1:0]  sample,
    input  logic signed [InputWidth-1:0]  coeff,
    input  logic                          flush,
    output logic [OutputWidth-1:0]        dout
);

    localparam int unsigned ProdWidth = 2 * InputWidth;

    logic signed [ProdWidth-1:0]   prod;
    logic signed [ProdWidth-1:0]   mult_pipe;
    logic signed [OutputWidth-1:0] ext;
    logic [OutputWidth-1:0]        sum;
    logic [OutputWidth-1:0]        result;
    logic [OutputWidth-1:0]        res_pipe;

    assign prod = sample * coeff;
    assign ext  = OutputWidth'(mult_pipe);
    // Wraps modulo 2^OutputWidth; no saturation by design
    assign sum  = ext + res_pipe;

    fir_pipe_reg #(
        .Width(ProdWidth)
    ) u_mult_pipe (
        .clk(clk),
        .rst(rst),
        .clr(flush),
        .en (1'b1),
        .d  (prod),
        .q  (mult_pipe)
    );

    fir_pipe_reg #(
        .Width(OutputWidth)
    ) u_result (
        .clk(clk),
        .rst(rst),
        .clr(flush),
        .en (1'b1),
        .d  (sum),
        .q  (result)
    );

    fir_pipe_reg #(
        .Width(OutputWidth)
    ) u_res_pipe (
        .clk(clk),
        .rst(rst),
        .clr(flush),
        .en (1'b1),
        .d  (result),
        .q  (res_pipe)
    );

    assign dout = result;

endmodule

// File: tb/tb_fir_mac_core.sv
// Self-checking bench for fir_mac_core against a product-history reference model.
module tb_fir_mac_core;

    localparam int IW = 16;
    localparam int OW = 38;

    logic                 clk;
    logic                 rst;
    logic signed [IW-1:0] sample;
    logic signed [IW-1:0] coeff;
    logic                 flush;
    logic [OW-1:0]        dout;

    int total;
    int bad;

    // Products (sign-extended) applied on each edge since the last clear
    logic [OW-1:0] hist[$];

    fir_mac_core #(
        .InputWidth (IW),
        .OutputWidth(OW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sample(sample),
        .coeff (coeff),
        .flush (flush),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // dout after n edges = products of edges n-1, n-3, ... (1-based), mod 2^OW
    function automatic logic [OW-1:0] model_dout();
        logic [OW-1:0] acc;
        acc = '0;
        for (int i = hist.size() - 2; i >= 0; i -= 2) acc += hist[i];
        return acc;
    endfunction

    task automatic step(input logic [IW-1:0] s, input logic [IW-1:0] c, input logic f,
                        input string tag);
        logic signed [2*IW-1:0] p;
        @(negedge clk);
        sample = s;
        coeff  = c;
        flush  = f;
        @(posedge clk);
        #1;
        if (f) begin
            hist.delete();
        end else begin
            p = $signed(s) * $signed(c);
            hist.push_back({{(OW-2*IW){p[2*IW-1]}}, p});
        end
        check(tag, dout, model_dout());
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", dout, '0);
        @(negedge clk);
        rst    = 1'b0;
        sample = '0;
        coeff  = '0;
        flush  = 1'b0;
        hist.delete();
    endtask

    logic [OW-1:0] const_exp[6];
    logic [OW-1:0] flush_exp[4];

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        sample = '0;
        coeff  = '0;
        flush  = 1'b0;
        const_exp = '{38'd0, 38'd6, 38'd6, 38'd12, 38'd12, 38'd18};
        flush_exp = '{38'd0, 38'd6, 38'd6, 38'd12};
        #12;
        check("reset_state", dout, '0);
        @(negedge clk);
        rst = 1'b0;

        // Constant accumulation, spec values
        for (int i = 0; i < 6; i++) begin
            step(16'd2, 16'd3, 1'b0, "const_model");
            check($sformatf("const_edge%0d", i + 1), dout, const_exp[i]);
        end

        // Mid-run async reset with nonzero state
        do_reset();

        // Flush mid-run
        for (int i = 0; i < 4; i++) step(16'd2, 16'd3, 1'b0, "pre_flush");
        check("pre_flush_12", dout, 38'd12);
        step(16'd2, 16'd3, 1'b1, "flush_edge");
        check("flush_zero", dout, '0);
        for (int i = 0; i < 4; i++) begin
            step(16'd2, 16'd3, 1'b0, "post_flush_model");
            check($sformatf("post_flush%0d", i + 1), dout, flush_exp[i]);
        end

        // Negative sign extension
        do_reset();
        step(16'hFFFF, 16'd1, 1'b0, "neg_e1");
        step(16'd0, 16'd0, 1'b0, "neg_e2");
        check("neg_edge2", dout, 38'h3F_FFFF_FFFF);
        step(16'd0, 16'd0, 1'b0, "neg_e3");
        step(16'd0, 16'd0, 1'b0, "neg_e4");
        check("neg_edge4", dout, 38'h3F_FFFF_FFFF);

        // Extreme product
        do_reset();
        step(16'h8000, 16'h8000, 1'b0, "ext_e1");
        step(16'd0, 16'd0, 1'b0, "ext_e2");
        check("extreme_edge2", dout, 38'h00_4000_0000);

        // Wrap-around: 256 products of 2^30 per partial sum reach 2^38
        do_reset();
        for (int i = 0; i < 520; i++) step(16'h8000, 16'h8000, 1'b0, "wrap_model");

        // Randomised run with occasional flushes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(IW'($urandom), IW'($urandom), ($urandom_range(0, 15) == 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
